// File: rtl/soc_mem_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, requester IDs and defaults.
package soc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_LS = 2'd2
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of LS grants taken while fetch was waiting; full lets IF win the next arbitration.
module mem_arb_starve_cnt
    import soc_mem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic full
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign full = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit, one transaction at a time.
module mem_port_arbiter
    import soc_mem_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                fetch_stall
);

    arb_state_t state, state_nxt;

    logic                any_req;
    logic                winner;
    logic                starve_full;
    logic                grant_if;
    logic                grant_ls;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;

    // LS has priority unless fetch has been passed over STARVE_MAX times in a row.
    always_comb begin
        any_req = if_req || ls_req;
        winner  = (ls_req && !(if_req && starve_full)) ? PORT_LS : PORT_IF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = (winner == PORT_LS) ? ST_BUSY_LS : ST_BUSY_IF;
                end
            end
            ST_BUSY_IF, ST_BUSY_LS: begin
                if (mem_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grants are gated by rst so nothing is accepted while reset is asserted.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        mem_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                grant_if = rst && any_req && (winner == PORT_IF);
                grant_ls = rst && any_req && (winner == PORT_LS);
            end
            ST_BUSY_IF, ST_BUSY_LS: mem_req = 1'b1;
            default: ;
        endcase
    end

    assign if_gnt = grant_if;
    assign ls_gnt = grant_ls;

    always_ff @(posedge clk) begin
        if (grant_ls) begin
            we_q    <= ls_we;
            addr_q  <= ls_addr;
            wdata_q <= ls_wdata;
            wstrb_q <= ls_wstrb;
        end else if (grant_if) begin
            we_q    <= 1'b0;
            addr_q  <= if_addr;
            wdata_q <= '0;
            wstrb_q <= '0;
        end
    end

    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q  : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign mem_wstrb = mem_req ? wstrb_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            if_rvalid <= (state == ST_BUSY_IF) && mem_ready;
            ls_rvalid <= (state == ST_BUSY_LS) && mem_ready;
            if ((state == ST_BUSY_IF) && mem_ready) begin
                if_rdata <= mem_rdata;
            end
            // Store completions are acks only; load data is left untouched.
            if ((state == ST_BUSY_LS) && mem_ready && !we_q) begin
                ls_rdata <= mem_rdata;
            end
        end
    end

    assign fetch_stall = !if_rvalid;

    mem_arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (grant_ls && if_req),
        .clr  (grant_if),
        .full (starve_full)
    );

endmodule
